// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a byte stream (16-bit LE word count, count*4 LE data bytes, one
// XOR checksum byte), writes each assembled 32-bit word into IMEM and
// releases the core from reset once the checksum matches.
// ADDR_WIDTH is expected to lie in 1..16 because the word count is 16 bits.

module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_waddr,
    output logic [31:0] o_imem_wdata,
    output logic        o_core_rst_n,
    output logic        o_load_done,
    output logic        o_load_error
);

    // Capacity in words; 17 bits so that 2**16 is representable.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [15:0]             r_count;
    logic [1:0]              r_byte_cnt;
    logic [ADDR_WIDTH-1:0]   r_word_idx;
    logic [7:0]              r_xor_acc;
    logic [31:0]             r_word;

    logic                    w_xfer;
    logic [15:0]             w_count_hdr;
    logic [16:0]             w_idx_plus1;
    logic [31:0]             w_word_asm;

    logic                    w_in_ready_next;
    logic                    w_imem_we_next;
    logic [31:0]             w_imem_waddr_next;
    logic [31:0]             w_imem_wdata_next;
    logic                    w_core_rst_n_next;
    logic                    w_load_done_next;
    logic                    w_load_error_next;

    // A byte moves only when the registered ready coincides with valid.
    assign w_xfer      = i_in_valid && o_in_ready;
    // Full count as it will be once the high header byte is latched.
    assign w_count_hdr = {i_in_data, r_count[7:0]};
    // Widened so the compare against count cannot wrap at MAX_WORDS.
    assign w_idx_plus1 = 17'(r_word_idx) + 17'd1;

    // Word as it will look after the current byte lands in lane r_byte_cnt.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_word_asm[gi*8 +: 8] =
                (w_xfer && (r_byte_cnt == 2'(gi))) ? i_in_data : r_word[gi*8 +: 8];
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_HDR_LO;
            S_HDR_LO: if (w_xfer) w_state_next = S_HDR_HI;
            S_HDR_HI: begin
                if (w_xfer) begin
                    if (w_count_hdr == 16'd0)
                        w_state_next = S_CHK;
                    else if (17'(w_count_hdr) > MAX_WORDS)
                        w_state_next = S_ERROR;
                    else
                        w_state_next = S_DATA;
                end
            end
            S_DATA:   if (w_xfer && (r_byte_cnt == 2'd3)) w_state_next = S_WRITE;
            S_WRITE: begin
                if (w_idx_plus1 == {1'b0, r_count})
                    w_state_next = S_CHK;
                else
                    w_state_next = S_DATA;
            end
            S_CHK: begin
                if (w_xfer)
                    w_state_next = (i_in_data == r_xor_acc) ? S_DONE : S_ERROR;
            end
            S_DONE:   w_state_next = S_DONE;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is registered and
    // changes on the same edge that enters the state.
    always_comb begin
        w_in_ready_next   = (w_state_next == S_HDR_LO) || (w_state_next == S_HDR_HI) ||
                            (w_state_next == S_DATA)   || (w_state_next == S_CHK);
        w_imem_we_next    = (w_state_next == S_WRITE);
        w_core_rst_n_next = (w_state_next == S_DONE);
        w_load_done_next  = (w_state_next == S_DONE);
        w_load_error_next = (w_state_next == S_ERROR);
        w_imem_waddr_next = o_imem_waddr;
        w_imem_wdata_next = o_imem_wdata;
        // WRITE is only ever entered from DATA on the 4th byte of a word.
        if (w_state_next == S_WRITE) begin
            w_imem_waddr_next = 32'({r_word_idx, 2'b00});
            w_imem_wdata_next = w_word_asm;
        end
    end

    // Output registers; reset forces the core back into reset at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_in_ready   <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_waddr <= 32'd0;
            o_imem_wdata <= 32'd0;
            o_core_rst_n <= 1'b0;
            o_load_done  <= 1'b0;
            o_load_error <= 1'b0;
        end else begin
            o_in_ready   <= w_in_ready_next;
            o_imem_we    <= w_imem_we_next;
            o_imem_waddr <= w_imem_waddr_next;
            o_imem_wdata <= w_imem_wdata_next;
            o_core_rst_n <= w_core_rst_n_next;
            o_load_done  <= w_load_done_next;
            o_load_error <= w_load_error_next;
        end
    end

    // Datapath: header latch, word assembly, checksum and word index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_xor_acc  <= 8'd0;
            r_word     <= 32'd0;
        end else begin
            case (r_state)
                S_HDR_LO: if (w_xfer) r_count[7:0]  <= i_in_data;
                S_HDR_HI: if (w_xfer) r_count[15:8] <= i_in_data;
                S_DATA: begin
                    if (w_xfer) begin
                        r_word     <= w_word_asm;
                        r_xor_acc  <= r_xor_acc ^ i_in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE:  r_word_idx <= w_idx_plus1[ADDR_WIDTH-1:0];
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a default-size instance and an
// ADDR_WIDTH=2 instance share the byte stream; only one is out of reset at a
// time and the selected one is observed.

module tb_imem_boot_loader;

    logic        clk;
    logic        rst_a_n, rst_b_n;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        a_ready, a_we, a_core, a_done, a_err;
    logic [31:0] a_waddr, a_wdata;
    logic        b_ready, b_we, b_core, b_done, b_err;
    logic [31:0] b_waddr, b_wdata;

    logic        sel;
    logic        w_ready, w_we, w_core, w_done, w_err;
    logic [31:0] w_waddr, w_wdata;

    int          n_cmp;
    int          n_err;
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];

    imem_boot_loader u_dut (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(a_ready), .o_imem_we(a_we), .o_imem_waddr(a_waddr),
        .o_imem_wdata(a_wdata), .o_core_rst_n(a_core), .o_load_done(a_done),
        .o_load_error(a_err)
    );

    imem_boot_loader #(.ADDR_WIDTH(2)) u_small (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(b_ready), .o_imem_we(b_we), .o_imem_waddr(b_waddr),
        .o_imem_wdata(b_wdata), .o_core_rst_n(b_core), .o_load_done(b_done),
        .o_load_error(b_err)
    );

    assign w_ready = sel ? b_ready : a_ready;
    assign w_we    = sel ? b_we    : a_we;
    assign w_waddr = sel ? b_waddr : a_waddr;
    assign w_wdata = sel ? b_wdata : a_wdata;
    assign w_core  = sel ? b_core  : a_core;
    assign w_done  = sel ? b_done  : a_done;
    assign w_err   = sel ? b_err   : a_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pops one expected write per observed strobe; ready must be low then.
    task automatic watch_writes();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (w_we) begin
                $display("write addr=0x%08h data=0x%08h", w_waddr, w_wdata);
                check("ready_in_write", {31'd0, w_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", w_waddr, e[63:32]);
                    check("wdata", w_wdata, e[31:0]);
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, w_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, w_we},    32'd0);
        check({tag, "_waddr"}, w_waddr,          32'd0);
        check({tag, "_wdata"}, w_wdata,          32'd0);
        check({tag, "_core"},  {31'd0, w_core},  32'd0);
        check({tag, "_done"},  {31'd0, w_done},  32'd0);
        check({tag, "_err"},   {31'd0, w_err},   32'd0);
    endtask

    // Resets both instances, checks reset values, releases the selected one.
    task automatic reset_dut(input logic which);
        @(negedge clk);
        in_valid = 1'b0;
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        exp_q.delete();
        sel = which;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        if (which) rst_b_n = 1'b1; else rst_a_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit ok;
        ok = 1'b0;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (w_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("byte_timeout", 32'd1, 32'd0);
    endtask

    // Models the expected writes and outcome of `stream`, drives it, checks.
    task automatic run_case(input string tag, input int max_w, input bit stall);
        int         cnt;
        logic [7:0] x;
        logic [31:0] word;
        bit         exp_done;
        cnt = int'({stream[1], stream[0]});
        x   = 8'd0;
        if (cnt > max_w) begin
            exp_done = 1'b0;
        end else begin
            for (int w = 0; w < cnt; w++) begin
                word = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    x ^= stream[2 + 4*w + k];
                    word[8*k +: 8] = stream[2 + 4*w + k];
                end
                exp_q.push_back({32'(w * 4), word});
            end
            exp_done = (stream[2 + 4*cnt] == x);
        end
        foreach (stream[i]) send_byte(stream[i], stall);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done"},  {31'd0, w_done},  {31'd0, exp_done});
        check({tag, "_err"},   {31'd0, w_err},   {31'd0, !exp_done});
        check({tag, "_core"},  {31'd0, w_core},  {31'd0, exp_done});
        check({tag, "_ready"}, {31'd0, w_ready}, 32'd0);
        check({tag, "_wr_left"}, exp_q.size(), 32'd0);
        // Terminal states must ignore further bytes.
        in_valid = 1'b1;
        repeat (3) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_hold_done"}, {31'd0, w_done}, {31'd0, exp_done});
        check({tag, "_hold_err"},  {31'd0, w_err},  {31'd0, !exp_done});
        $display("case %s: done=%0b err=%0b core_rst_n=%0b", tag, w_done, w_err, w_core);
    endtask

    task automatic set_nominal(input logic [7:0] chk);
        stream = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                   8'h93, 8'h01, 8'h31, 8'h00, chk};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        n_cmp    = 0;
        n_err    = 0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        sel      = 1'b0;
        fork
            watch_writes();
        join_none

        reset_dut(1'b0); set_nominal(8'hE1); run_case("nominal", 1024, 1'b0);
        reset_dut(1'b0); set_nominal(8'hE0); run_case("bad_chk", 1024, 1'b0);
        reset_dut(1'b0); stream = '{8'h00, 8'h00, 8'h00}; run_case("zero_ok", 1024, 1'b0);
        reset_dut(1'b0); stream = '{8'h00, 8'h00, 8'h05}; run_case("zero_bad", 1024, 1'b0);

        reset_dut(1'b1); stream = '{8'h05, 8'h00}; run_case("oversize", 4, 1'b0);
        reset_dut(1'b1);
        stream = '{8'h04, 8'h00};
        x = 8'd0;
        for (int i = 0; i < 16; i++) begin
            stream.push_back(8'($urandom));
            x ^= stream[i + 2];
        end
        stream.push_back(x);
        run_case("full_small", 4, 1'b0);

        reset_dut(1'b0); set_nominal(8'hE1); run_case("stall", 1024, 1'b1);
        reset_dut(1'b1); set_nominal(8'hE1); run_case("stall_small", 4, 1'b1);

        // Reset after the 6th byte: the first word is written, then reset hits.
        reset_dut(1'b0);
        set_nominal(8'hE1);
        exp_q.push_back({32'h0, 32'h00500113});
        for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
        in_valid = 1'b0;
        #2 rst_a_n = 1'b0;
        #1 check_reset_vals("midrst");
        check("midrst_wr_left", exp_q.size(), 32'd0);
        $display("case midrst: outputs after async reset checked");
        reset_dut(1'b0); set_nominal(8'hE1); run_case("replay", 1024, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the single-cycle core and its instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit instruction words.
- Writes each word into IMEM through a dedicated write port, then checks an XOR checksum.
- Holds the core in reset (core_rst_n low) until the program has loaded and the checksum has matched.

Parameters:
- ADDR_WIDTH, 10, IMEM word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle (registered)
- imem_we  output  1  IMEM write strobe, one cycle per word
- imem_waddr  output  32  IMEM byte address, word-aligned (word_idx*4)
- imem_wdata  output  32  assembled instruction word
- core_rst_n  output  1  active-low reset to the core; high only in DONE
- load_done  output  1  sticky: program loaded, checksum OK
- load_error  output  1  sticky: oversize count or checksum mismatch

Behaviour:
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_data is ignored when in_valid is low.
- Stream format:
  - count_lo, count_hi: 16-bit word count, little-endian.
  - count*4 data bytes: each word little-endian; the first byte goes to bits 7:0.
  - One checksum byte: XOR of all data bytes; header bytes are excluded.
- States are IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERROR.
- Reset (async, rst_n low): state = IDLE; in_ready = 0, imem_we = 0, imem_waddr = 0, imem_wdata = 0, core_rst_n = 0, load_done = 0, load_error = 0; byte_cnt, word_idx and xor_acc = 0.
- IDLE: lasts one cycle, then goes to HDR_LO. in_ready rises on that edge.
- HDR_LO: on transfer, latch count[7:0] and go to HDR_HI.
- HDR_HI: on transfer, latch count[15:8], then:
  - count == 0: go to CHK (expected checksum 0x00).
  - count > MAX_WORDS: go to ERROR.
  - otherwise: go to DATA.
- DATA: on transfer, shift the byte into lane byte_cnt and XOR it into xor_acc. byte_cnt wraps mod 4; the 4th byte moves to WRITE.
- WRITE: lasts exactly one cycle with in_ready = 0.
  - imem_we = 1, imem_waddr = {word_idx,2'b00} zero-extended, imem_wdata = assembled word.
  - Then word_idx increments. If word_idx+1 == count, go to CHK; else go to DATA.
- All outputs are registered. imem_we and imem_waddr/imem_wdata are valid during the same cycle. in_ready drops on the edge that enters WRITE, so the next byte is accepted no earlier than 2 cycles after the 4th byte.
- CHK: on transfer, if in_data == xor_acc go to DONE, else go to ERROR.
- DONE: terminal until reset; in_ready = 0, load_done = 1, core_rst_n = 1. All three are set on the entering edge. Further bytes are ignored.
- ERROR: terminal until reset; in_ready = 0, load_error = 1, core_rst_n stays 0. IMEM contents already written are left as is.
- load_done and load_error are never both 1.
- imem_we is never asserted outside WRITE.
- Reset mid-load returns to IDLE immediately, drops core_rst_n and in_ready asynchronously, and discards the partial word (no write).
- Stalls: in_valid low for any number of cycles pauses all progress without losing state.
- A count exactly equal to MAX_WORDS is legal; the last address is (MAX_WORDS-1)*4.

Test Plan:
- Nominal: stream 02 00 13 01 50 00 93 01 31 00 E1 with in_valid held high.
  - Exactly two imem_we pulses: addr 0x0 data 0x00500113, then addr 0x4 data 0x00310193.
  - Then load_done=1, core_rst_n=1, load_error=0.
- Checksum fail: same stream with the last byte 0xE0 -> load_error=1, core_rst_n=0, two writes still observed.
- Zero count: stream 00 00 00 -> no imem_we, load_done=1. With 00 00 05 instead -> load_error=1.
- Oversize, ADDR_WIDTH=2: header 05 00 -> ERROR immediately after HDR_HI, no writes. Header 04 00 plus 16 bytes plus correct XOR -> 4 writes at 0x0..0xC, then DONE.
- Backpressure/stall: in_valid toggled randomly during the nominal stream.
  - Identical writes and result.
  - in_ready low in every WRITE cycle.
  - No byte is accepted in a WRITE cycle.
- Reset mid-load: assert rst_n low after the 6th byte of the nominal stream.
  - All outputs return to reset values asynchronously.
  - Replaying the full stream yields the nominal result.
